dbi_encoder_multilane: RTL and testbench

Parametrised multi-lane Data Bus Inversion encoder for the systolic array's inter-PE and array-to-memory buses. Each lane independently decides per beat whether to send its word true or inverted and emits one DBI flag per lane.
- Supports AC mode (minimise transitions against the previously transmitted lane word) and DC mode (minimise ones).
- Uses a valid/ready handshake with a single registered output stage.
- Keeps a saturating inversion counter for power characterisation.

---
 rtl/dbi_encoder_multilane.sv | 156 +++++++++++++++
 tb/tb_dbi_encoder_multilane.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dbi_encoder_multilane.sv
// Multi-lane Data Bus Inversion encoder with a single registered output stage.
// Each lane independently picks true or inverted transmission per beat (AC: fewest
// transitions against the last transmitted lane word, DC: fewest ones) and reports
// one DBI flag per lane. A saturating counter totals lane inversions.
module dbi_encoder_multilane #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned LANE_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                mode_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [LANES*LANE_W-1:0]   in_data_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [LANES*LANE_W-1:0]   out_data_o,
   output logic [LANES-1:0]          out_dbi_o,
   input  logic                      cnt_clr_i,
   output logic [CNT_W-1:0]          inv_count_o
);

   // Popcount width must hold the value LANE_W itself.
   localparam int unsigned    PCW  = $clog2(LANE_W + 1);
   localparam logic [PCW-1:0] HALF = PCW'(LANE_W / 2);
   // Width of the per-beat inverted-lane count (0..LANES).
   localparam int unsigned    NW   = $clog2(LANES + 1);
   // Counter sum width with headroom so saturation can be detected.
   localparam int unsigned    SW   = CNT_W + NW;

   typedef enum logic [1:0] {
      ModeBypass = 2'b00,
      ModeAc     = 2'b01,
      ModeDc     = 2'b10,
      ModeRsvd   = 2'b11
   } mode_e;

   function automatic logic [PCW-1:0] popcnt(input logic [LANE_W-1:0] w);
      logic [PCW-1:0] c;
      c = '0;
      for (int unsigned b = 0; b < LANE_W; b++) begin
         c = c + PCW'(w[b]);
      end
      return c;
   endfunction

   logic                     out_valid_q, out_valid_d;
   logic [LANES*LANE_W-1:0]  out_data_q, out_data_d;
   logic [LANES-1:0]         out_dbi_q, out_dbi_d;
   logic [LANES*LANE_W-1:0]  prev_word_q, prev_word_d;
   logic [LANES-1:0]         prev_dbi_q, prev_dbi_d;
   logic [CNT_W-1:0]         inv_count_q, inv_count_d;

   logic                     accept;
   logic [LANES*LANE_W-1:0]  enc_data;
   logic [LANES-1:0]         enc_dbi;
   logic [NW-1:0]            inv_num;
   logic [SW-1:0]            cnt_sum;
   logic [LANE_W-1:0]        lane_w;
   logic [PCW-1:0]           lane_t;
   logic [PCW-1:0]           lane_o;
   logic                     lane_inv;

   assign in_ready_o = !out_valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;

   // Per-lane inversion decision and encoded word for the beat on in_data_i.
   always_comb begin
      enc_data = '0;
      enc_dbi  = '0;
      inv_num  = '0;
      lane_w   = '0;
      lane_t   = '0;
      lane_o   = '0;
      lane_inv = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_w   = in_data_i[i*LANE_W +: LANE_W];
         lane_t   = popcnt(lane_w ^ prev_word_q[i*LANE_W +: LANE_W]);
         lane_o   = popcnt(lane_w);
         lane_inv = 1'b0;
         case (mode_e'(mode_i))
            ModeAc: begin
               if (lane_t > HALF) begin
                  lane_inv = 1'b1;
               end else if (lane_t == HALF) begin
                  // Tie: repeat the previous flag so the DBI wire does not toggle.
                  lane_inv = prev_dbi_q[i];
               end
            end
            ModeDc:  lane_inv = (lane_o > HALF);
            default: lane_inv = 1'b0;
         endcase
         enc_dbi[i]                    = lane_inv;
         enc_data[i*LANE_W +: LANE_W]  = lane_inv ? ~lane_w : lane_w;
         inv_num                       = inv_num + NW'(lane_inv);
      end
   end

   // Next state for the output stage, AC reference and inversion counter.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_dbi_d   = out_dbi_q;
      prev_word_d = prev_word_q;
      prev_dbi_d  = prev_dbi_q;
      inv_count_d = inv_count_q;
      cnt_sum     = SW'(inv_count_q) + SW'(inv_num);

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = enc_data;
         out_dbi_d   = enc_dbi;
         // Reference tracks the wire value in every mode.
         prev_word_d = enc_data;
         prev_dbi_d  = enc_dbi;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end

      if (cnt_clr_i) begin
         inv_count_d = '0;
      end else if (accept) begin
         if (|cnt_sum[SW-1:CNT_W]) begin
            inv_count_d = '1;
         end else begin
            inv_count_d = cnt_sum[CNT_W-1:0];
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_dbi_q   <= '0;
         prev_word_q <= '0;
         prev_dbi_q  <= '0;
         inv_count_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_dbi_q   <= out_dbi_d;
         prev_word_q <= prev_word_d;
         prev_dbi_q  <= prev_dbi_d;
         inv_count_q <= inv_count_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_dbi_o   = out_dbi_q;
   assign inv_count_o = inv_count_q;

endmodule

// File: tb/tb_dbi_encoder_multilane.sv
// Directed and random checks of dbi_encoder_multilane (2 lanes x 8 bits, 4-bit counter)
// against a behavioural model with an expected-beat queue.
module tb_dbi_encoder_multilane;

   logic        clk;
   logic        reset;
   logic [1:0]  mode;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [1:0]  out_dbi;
   logic        cnt_clr;
   logic [3:0]  inv_count;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  b;
   } beat_t;

   beat_t       sb[$];
   logic [7:0]  m_pw[2];
   logic        m_pd[2];
   logic        m_valid;
   logic [15:0] m_data;
   logic [1:0]  m_dbi;
   int          m_cnt;

   dbi_encoder_multilane #(
      .LANES  (2),
      .LANE_W (8),
      .CNT_W  (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mode_i      (mode),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_dbi_o   (out_dbi),
      .cnt_clr_i   (cnt_clr),
      .inv_count_o (inv_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare after the edge.
   task automatic step(input logic rst, input logic [1:0] md, input logic v,
                       input logic [15:0] d, input logic ordy, input logic clr);
      logic       acc;
      beat_t      e;
      beat_t      got;
      logic [7:0] w;
      logic       inv;
      int         t;
      int         n;
      reset     = rst;
      mode      = md;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      cnt_clr   = clr;
      #1;
      if (!rst) check("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
      acc = !rst && v && (!m_valid || ordy);
      e   = '0;
      n   = 0;
      if (rst) begin
         m_pw[0] = 8'h00; m_pw[1] = 8'h00;
         m_pd[0] = 1'b0;  m_pd[1] = 1'b0;
         m_valid = 1'b0;  m_data  = 16'h0; m_dbi = 2'b00; m_cnt = 0;
         sb.delete();
      end else begin
         if (acc) begin
            for (int l = 0; l < 2; l++) begin
               w   = d[l*8 +: 8];
               inv = 1'b0;
               if (md == 2'b01) begin
                  t = $countones(w ^ m_pw[l]);
                  inv = (t > 4) ? 1'b1 : (t < 4) ? 1'b0 : m_pd[l];
               end else if (md == 2'b10) begin
                  inv = ($countones(w) > 4);
               end
               e.d[l*8 +: 8] = inv ? ~w : w;
               e.b[l]        = inv;
               n             = n + int'(inv);
               m_pw[l]       = inv ? ~w : w;
               m_pd[l]       = inv;
            end
            sb.push_back(e);
            m_valid = 1'b1;
            m_data  = e.d;
            m_dbi   = e.b;
         end else if (ordy) begin
            m_valid = 1'b0;
         end
         if (clr) m_cnt = 0;
         else if (acc) m_cnt = (m_cnt + n > 15) ? 15 : m_cnt + n;
      end
      @(posedge clk);
      #1;
      if (acc) begin
         if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 32'd1);
         end else begin
            got = sb.pop_front();
            check("sb_data", 32'(out_data), 32'(got.d));
            check("sb_dbi", 32'(out_dbi), 32'(got.b));
         end
      end
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_dbi", 32'(out_dbi), 32'(m_dbi));
      check("inv_count", 32'(inv_count), 32'(m_cnt));
   endtask

   initial begin
      reset = 1'b1; mode = 2'b00; in_valid = 1'b0; in_data = 16'h0;
      out_ready = 1'b1; cnt_clr = 1'b0;

      // Reset state
      step(1'b1, 2'b00, 1'b0, 16'h0, 1'b1, 1'b0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_count", 32'(inv_count), 32'd0);

      // AC: lane1 inverts, lane0 ties and keeps dbi=0
      step(1'b0, 2'b01, 1'b1, 16'hFF0F, 1'b1, 1'b0);
      check("ac_data", 32'(out_data), 32'h000F);
      check("ac_dbi", 32'(out_dbi), 32'h2);
      check("ac_count", 32'(inv_count), 32'd1);

      // AC tie hold against wire 0000 with dbi 01
      step(1'b1, 2'b00, 1'b0, 16'h0, 1'b1, 1'b0);
      step(1'b0, 2'b01, 1'b1, 16'h00FF, 1'b1, 1'b0);
      check("ac_pre_dbi", 32'(out_dbi), 32'h1);
      step(1'b0, 2'b01, 1'b1, 16'h0F0F, 1'b1, 1'b0);
      check("tie_data", 32'(out_data), 32'h0FF0);
      check("tie_dbi", 32'(out_dbi), 32'h1);

      // DC mode, including a tie that stays true
      step(1'b0, 2'b10, 1'b1, 16'hFE11, 1'b1, 1'b0);
      check("dc_data", 32'(out_data), 32'h0111);
      check("dc_dbi", 32'(out_dbi), 32'h2);
      step(1'b0, 2'b10, 1'b1, 16'h0F0F, 1'b1, 1'b0);
      check("dc_tie_dbi", 32'(out_dbi), 32'h0);

      // Backpressure: held beat, changing input ignored, then release
      step(1'b0, 2'b01, 1'b1, 16'h1234, 1'b0, 1'b0);
      step(1'b0, 2'b01, 1'b1, 16'hA5C3, 1'b0, 1'b0);
      check("bp_ready", 32'(in_ready), 32'd0);
      step(1'b0, 2'b01, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      step(1'b0, 2'b01, 1'b1, 16'h00F0, 1'b0, 1'b0);
      step(1'b0, 2'b01, 1'b1, 16'hEDCB, 1'b1, 1'b0);
      step(1'b0, 2'b01, 1'b0, 16'h0000, 1'b1, 1'b0);
      check("drain_valid", 32'(out_valid), 32'd0);

      // Random traffic
      for (int k = 0; k < 100; k++) begin
         step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
              16'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 15) == 0));
      end
      step(1'b0, 2'b00, 1'b0, 16'h0, 1'b1, 1'b0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      // Bypass then switch to AC against the bypassed wire word
      step(1'b0, 2'b00, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      check("byp_data", 32'(out_data), 32'hFFFF);
      check("byp_dbi", 32'(out_dbi), 32'h0);
      step(1'b0, 2'b01, 1'b1, 16'h0000, 1'b1, 1'b0);
      check("sw_data", 32'(out_data), 32'hFFFF);
      check("sw_dbi", 32'(out_dbi), 32'h3);

      // Counter saturation, then clear beats a simultaneous inverting accept
      step(1'b1, 2'b00, 1'b0, 16'h0, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) step(1'b0, 2'b01, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      check("cnt_sat", 32'(inv_count), 32'hF);
      step(1'b0, 2'b01, 1'b1, 16'hFFFF, 1'b1, 1'b1);
      check("cnt_clr", 32'(inv_count), 32'h0);
      check("clr_beat_dbi", 32'(out_dbi), 32'h3);

      // Reset while a beat is held
      step(1'b0, 2'b01, 1'b1, 16'h1111, 1'b0, 1'b0);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      step(1'b1, 2'b01, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_dbi", 32'(out_dbi), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
